// File: rtl/fft_result_scanner.sv
// Steps an N-point FFT result snapshot onto a half-word display bus.
// Define SCAN_MAG_EN to add a |re|+|im| slot per point (mag_sel output).
module fft_result_scanner #(
  parameter int N_POINTS = 8,
  parameter int WORD_W   = 32,
  parameter int TICK_DIV = 134217728
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_POINTS*WORD_W-1:0]    results_in,
  input  logic                          results_valid,
  input  logic                          run,
  input  logic                          mode,
  input  logic                          step,
  input  logic                          loop_en,
  output logic [WORD_W/2-1:0]           array,
  output logic [$clog2(N_POINTS)-1:0]   point_idx,
  output logic                          half_sel,
  output logic                          busy,
  output logic                          done,
`ifdef SCAN_MAG_EN
  output logic                          mag_sel,
`endif
  output logic                          wrap
);

  localparam int HW = WORD_W / 2;
  localparam int IW = $clog2(N_POINTS);
  localparam int CW = $clog2(TICK_DIV);
`ifdef SCAN_MAG_EN
  localparam int SW = 2;
  localparam int NSUB = 3;
`else
  localparam int SW = 1;
  localparam int NSUB = 2;
`endif
  localparam logic [SW-1:0] SUB_LAST = SW'(NSUB - 1);
  localparam logic [IW-1:0] PT_LAST  = IW'(N_POINTS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] mem [N_POINTS];
  logic [SW-1:0]     sub;
  logic [CW-1:0]     cnt;
  logic              step_q;
  logic              auto_en;
  logic              tick;
  logic              adv;

`ifdef SCAN_MAG_EN
  // Halves are two's complement; -min needs one extra bit before summing.
  function automatic logic [HW-1:0] mag_of(input logic [WORD_W-1:0] w);
    logic [HW:0]   ar;
    logic [HW:0]   ai;
    logic [HW+1:0] sum;
    ar = {w[WORD_W-1], w[WORD_W-1:HW]};
    if (ar[HW]) ar = -ar;
    ai = {w[HW-1], w[HW-1:0]};
    if (ai[HW]) ai = -ai;
    sum = {1'b0, ar} + {1'b0, ai};
    if (sum > {2'b00, {HW{1'b1}}}) return '1;
    return sum[HW-1:0];
  endfunction

  assign mag_sel = (sub == 2'd2);
`endif

  assign half_sel = |sub;
  assign busy     = (state == SCAN);
  assign done     = (state == DONE);
  assign auto_en  = (state == SCAN) && !mode && run;
  assign tick     = (cnt == CNT_LAST);
  assign adv      = mode ? (step & ~step_q) : (auto_en & tick);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sub       <= '0;
      point_idx <= '0;
      cnt       <= '0;
      step_q    <= step;
      array     <= '1;
      wrap      <= 1'b0;
    end else begin
      step_q <= step;
      wrap   <= 1'b0;
      if (results_valid) begin
        for (int k = 0; k < N_POINTS; k++)
          mem[k] <= results_in[k*WORD_W +: WORD_W];
        state     <= SCAN;
        sub       <= '0;
        point_idx <= '0;
        cnt       <= '0;
        array     <= results_in[WORD_W-1:HW];
      end else begin
        if (auto_en)
          cnt <= tick ? '0 : cnt + 1'b1;
        if (state == SCAN && adv) begin
          unique case (1'b1)
            (sub != SUB_LAST): begin
              sub <= sub + 1'b1;
`ifdef SCAN_MAG_EN
              if (sub == 2'd1)
                array <= mag_of(mem[point_idx]);
              else
                array <= mem[point_idx][HW-1:0];
`else
              array <= mem[point_idx][HW-1:0];
`endif
            end
            (sub == SUB_LAST && point_idx != PT_LAST): begin
              sub       <= '0;
              point_idx <= point_idx + 1'b1;
              array     <= mem[point_idx + 1'b1][WORD_W-1:HW];
            end
            (sub == SUB_LAST && point_idx == PT_LAST && loop_en): begin
              sub       <= '0;
              point_idx <= '0;
              array     <= mem[0][WORD_W-1:HW];
              wrap      <= 1'b1;
            end
            default: state <= DONE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_result_scanner.sv
// Directed + random bench for fft_result_scanner against a slot-level model.
// Build with SCAN_MAG_EN defined to cover the magnitude slot.
module tb_fft_result_scanner;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int TD = 4;
`ifdef SCAN_MAG_EN
  localparam int NSL = 3;
`else
  localparam int NSL = 2;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] results_in;
  logic           results_valid;
  logic           run;
  logic           mode;
  logic           step;
  logic           loop_en;
  logic [15:0]    array;
  logic [2:0]     point_idx;
  logic           half_sel;
  logic           busy;
  logic           done;
  logic           wrap;
  logic           mag_obs;

  fft_result_scanner #(
    .N_POINTS(N),
    .WORD_W(W),
    .TICK_DIV(TD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .results_in(results_in),
    .results_valid(results_valid),
    .run(run),
    .mode(mode),
    .step(step),
    .loop_en(loop_en),
    .array(array),
    .point_idx(point_idx),
    .half_sel(half_sel),
    .busy(busy),
    .done(done),
`ifdef SCAN_MAG_EN
    .mag_sel(mag_obs),
`endif
    .wrap(wrap)
  );

`ifndef SCAN_MAG_EN
  assign mag_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 scan, 2 done; s is the slot number.
  int          m_state;
  int          m_s;
  int          m_cnt;
  bit          m_prev;
  bit          m_wrap;
  logic [31:0] m_buf [N];

  function automatic logic [15:0] slot_val(int s);
    logic [31:0] w;
    int sub, re, im, sum;
    w   = m_buf[s / NSL];
    sub = s % NSL;
    if (sub == 0) return w[31:16];
    if (sub == 1) return w[15:0];
    re  = $signed(w[31:16]);
    im  = $signed(w[15:0]);
    sum = (re < 0 ? -re : re) + (im < 0 ? -im : im);
    return (sum > 65535) ? 16'hFFFF : 16'(sum);
  endfunction

  task automatic model_step();
    bit rise, adv;
    if (reset) begin
      m_state = 0; m_s = 0; m_cnt = 0; m_prev = step; m_wrap = 0;
      return;
    end
    m_wrap = 0;
    rise   = step && !m_prev;
    m_prev = step;
    if (results_valid) begin
      for (int k = 0; k < N; k++) m_buf[k] = results_in[k*W +: W];
      m_s = 0; m_state = 1; m_cnt = 0;
      return;
    end
    adv = 0;
    if (m_state == 1 && !mode && run) begin
      if (m_cnt == TD - 1) begin m_cnt = 0; adv = 1; end
      else m_cnt++;
    end
    if (mode) adv = rise;
    if (m_state == 1 && adv) begin
      if (m_s < NSL * N - 1) m_s++;
      else if (loop_en) begin m_s = 0; m_wrap = 1; end
      else m_state = 2;
    end
  endtask

  task automatic check(string tag);
    logic [23:0] obs, exp;
    logic [15:0] ea;
    ea  = (m_state == 0) ? 16'hFFFF : slot_val(m_s);
    exp = {ea, 3'(m_s / NSL), (m_s % NSL) != 0, m_state == 1,
           m_state == 2, m_wrap, (m_s % NSL) == 2};
    obs = {array, point_idx, half_sel, busy, done, wrap, mag_obs};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(string tag);
    @(posedge clk);
    model_step();
    #1;
    check(tag);
  endtask

  task automatic load_pattern();
    for (int k = 0; k < N; k++)
      results_in[k*W +: W] = {16'h1000 + 16'(k), 16'h2000 + 16'(k)};
  endtask

  task automatic capture(string tag);
    results_valid = 1'b1;
    cyc(tag);
    results_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; results_valid = 1'b1; step = 1'b1;
    run = 1'b1; mode = 1'b0; loop_en = 1'b0;
    load_pattern();

    // 1: reset dominates capture and step
    repeat (3) cyc("reset");
    checks++;
    assert (array === 16'hFFFF) else begin
      errors++;
      $error("FAIL reset_array obs=%h exp=ffff", array);
    end
    reset = 1'b0; results_valid = 1'b0;
    repeat (3) cyc("idle_held_step");
    step = 1'b0;

    // 2: auto scan, no loop
    capture("cap_auto");
    checks++;
    assert (array === 16'h1000) else begin
      errors++;
      $error("FAIL cap_first obs=%h exp=1000", array);
    end
    repeat (NSL * N * TD + 8) cyc("auto_noloop");
    checks++;
    assert (done === 1'b1 && busy === 1'b0) else begin
      errors++;
      $error("FAIL done_flag obs=%b%b exp=10", done, busy);
    end

    // 3: loop, then pause
    loop_en = 1'b1;
    capture("cap_loop");
    repeat (NSL * N * TD + 6) cyc("auto_loop");
    run = 1'b0;
    repeat (10) cyc("paused");
    run = 1'b1;
    repeat (12) cyc("resumed");

    // 4: manual stepping
    mode = 1'b1; loop_en = 1'b0;
    capture("cap_manual");
    step = 1'b1;
    repeat (10) cyc("step_held");
    step = 1'b0;
    repeat (3) cyc("step_low");
    step = 1'b1;
    repeat (3) cyc("step_high2");
    step = 1'b0;

    // 5: recapture mid-scan; input changes are not displayed
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; cyc("to_slot5");
      step = 1'b0; cyc("to_slot5");
    end
    results_in = {N*W/32{$urandom}};
    repeat (4) cyc("inputs_changed");
    results_in[31:0] = {16'hAAAA, 16'h5555};
    capture("recapture");
    checks++;
    assert (array === 16'hAAAA) else begin
      errors++;
      $error("FAIL recap_array obs=%h exp=aaaa", array);
    end

    // 6: reset mid-scan, then magnitude corner points
    mode = 1'b0; run = 1'b1; load_pattern();
    capture("cap_for_reset");
    repeat (9 * TD) cyc("to_slot9");
    reset = 1'b1;
    cyc("reset_mid");
    reset = 1'b0;
    cyc("after_reset");
    results_in[31:0]  = 32'hFFFE_0003;
    results_in[63:32] = 32'h8000_8000;
    results_in[95:64] = 32'h7FFF_7FFF;
    mode = 1'b1; step = 1'b0;
    capture("cap_mag");
    for (int i = 0; i < 3 * NSL; i++) begin
      step = 1'b1; cyc("mag_walk");
      step = 1'b0; cyc("mag_walk");
    end

    // Random phase
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 199) == 0);
      results_valid = ($urandom_range(0, 39) == 0);
      if (results_valid)
        for (int k = 0; k < N; k++) results_in[k*W +: W] = $urandom;
      run     = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      step    = $urandom_range(0, 1);
      loop_en = ($urandom_range(0, 3) != 0);
      cyc("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
